// File: rtl/t03_mmio_periph.sv
// t03_mmio_periph
// Memory-mapped peripheral block that sits beside data memory on a simple
// CPU bus. It provides a GPIO output register, a synchronised GPIO input
// port with rising-edge capture and a level interrupt, and NUM_PWM PWM
// channels with double-buffered period/duty registers.
//
// Register map (byte offsets from BASE_ADDR, exact-match decode):
//   0x00        GPIO_OUT   RW
//   0x04        GPIO_IN    RO   (synchronised pin state)
//   0x08        EDGE_STAT  R/W1C
//   0x0C        EDGE_EN    RW
//   0x10 + 8*i  PERIOD[i]  RW   (shadow)
//   0x14 + 8*i  DUTY[i]    RW   (shadow)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   write_mem         CPU store strobe
//   read_mem          CPU load strobe
//   data_address      CPU byte address
//   data_to_write     store data
//   data_from_mem     memory load data, forwarded when not an IO load
//   data_read         load data returned to the CPU (combinational)
//   io_hit            address matches a mapped register (combinational)
//   gpio_in           asynchronous input pins
//   gpio_out          output pin register
//   pwm_out           PWM waveforms, one per channel
//   irq               level interrupt, any enabled captured edge

module t03_mmio_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h31FFFF00,
    parameter int          GPIO_W    = 32,
    parameter int          NUM_PWM   = 2,
    parameter int          PWM_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_mem,
    input  logic               read_mem,
    input  logic [31:0]        data_address,
    input  logic [31:0]        data_to_write,
    input  logic [31:0]        data_from_mem,
    output logic [31:0]        data_read,
    output logic               io_hit,
    input  logic [GPIO_W-1:0]  gpio_in,
    output logic [GPIO_W-1:0]  gpio_out,
    output logic [NUM_PWM-1:0] pwm_out,
    output logic               irq
);

    logic [GPIO_W-1:0] r_gpioOut;
    logic [GPIO_W-1:0] r_s1;
    logic [GPIO_W-1:0] r_s2;
    logic [GPIO_W-1:0] r_s3;
    logic [GPIO_W-1:0] r_edgeStat;
    logic [GPIO_W-1:0] r_edgeEn;

    logic [PWM_W-1:0]  r_periodSh  [NUM_PWM];
    logic [PWM_W-1:0]  r_dutySh    [NUM_PWM];
    logic [PWM_W-1:0]  r_periodAct [NUM_PWM];
    logic [PWM_W-1:0]  r_dutyAct   [NUM_PWM];
    logic [PWM_W-1:0]  r_cnt       [NUM_PWM];

    logic [31:0]        w_offset;
    logic               w_selGpioOut;
    logic               w_selGpioIn;
    logic               w_selEdgeStat;
    logic               w_selEdgeEn;
    logic [NUM_PWM-1:0] w_selPeriod;
    logic [NUM_PWM-1:0] w_selDuty;
    logic [NUM_PWM-1:0] w_load;
    logic [31:0]        w_regRead;
    logic [GPIO_W-1:0]  w_w1c;
    logic [GPIO_W-1:0]  w_edgeRise;

    // Address decode. Subtracting the base lets every register be compared
    // against a small constant offset; only exact word offsets match.
    always_comb begin
        w_offset      = data_address - BASE_ADDR;
        w_selGpioOut  = (w_offset == 32'h00);
        w_selGpioIn   = (w_offset == 32'h04);
        w_selEdgeStat = (w_offset == 32'h08);
        w_selEdgeEn   = (w_offset == 32'h0C);
        w_selPeriod   = '0;
        w_selDuty     = '0;
        for (int i = 0; i < NUM_PWM; i++) begin
            w_selPeriod[i] = (w_offset == 32'(16 + 8 * i));
            w_selDuty[i]   = (w_offset == 32'(20 + 8 * i));
        end
        io_hit = w_selGpioOut | w_selGpioIn | w_selEdgeStat | w_selEdgeEn
               | (|w_selPeriod) | (|w_selDuty);
    end

    // Read mux. A simultaneous store takes priority, so an IO value is only
    // returned on a pure load of a mapped address; everything else forwards
    // memory data.
    always_comb begin
        w_regRead = '0;
        if (w_selGpioOut)  w_regRead = 32'(r_gpioOut);
        if (w_selGpioIn)   w_regRead = 32'(r_s2);
        if (w_selEdgeStat) w_regRead = 32'(r_edgeStat);
        if (w_selEdgeEn)   w_regRead = 32'(r_edgeEn);
        for (int i = 0; i < NUM_PWM; i++) begin
            if (w_selPeriod[i]) w_regRead = 32'(r_periodSh[i]);
            if (w_selDuty[i])   w_regRead = 32'(r_dutySh[i]);
        end
        data_read = (read_mem && !write_mem && io_hit) ? w_regRead : data_from_mem;
    end

    // Edge capture: a new rising edge is OR-ed in after the W1C mask, so a
    // fresh edge survives a clear of the same bit in the same cycle.
    assign w_edgeRise = r_s2 & ~r_s3;
    assign w_w1c      = (write_mem && w_selEdgeStat) ? data_to_write[GPIO_W-1:0] : '0;

    // GPIO registers, the input synchroniser chain and edge status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpioOut  <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_edgeStat <= '0;
            r_edgeEn   <= '0;
        end else begin
            r_s1       <= gpio_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_edgeStat <= (r_edgeStat & ~w_w1c) | w_edgeRise;
            if (write_mem && w_selGpioOut) r_gpioOut <= data_to_write[GPIO_W-1:0];
            if (write_mem && w_selEdgeEn)  r_edgeEn  <= data_to_write[GPIO_W-1:0];
        end
    end

    // A channel reloads its active pair while idle (period 0) and at the end
    // of every PWM cycle, so software updates never truncate a cycle.
    always_comb begin
        for (int i = 0; i < NUM_PWM; i++) begin
            w_load[i] = (r_periodAct[i] == '0) || (r_cnt[i] == r_periodAct[i]);
        end
    end

    // PWM shadows, active values and counters. The shadow write and the
    // active load use the pre-edge shadow, so a coinciding write only takes
    // effect at the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PWM; i++) begin
                r_periodSh[i]  <= '0;
                r_dutySh[i]    <= '0;
                r_periodAct[i] <= '0;
                r_dutyAct[i]   <= '0;
                r_cnt[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PWM; i++) begin
                if (write_mem && w_selPeriod[i]) r_periodSh[i] <= data_to_write[PWM_W-1:0];
                if (write_mem && w_selDuty[i])   r_dutySh[i]   <= data_to_write[PWM_W-1:0];
                if (w_load[i]) begin
                    r_periodAct[i] <= r_periodSh[i];
                    r_dutyAct[i]   <= r_dutySh[i];
                    r_cnt[i]       <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Waveform and interrupt outputs.
    always_comb begin
        for (int i = 0; i < NUM_PWM; i++) begin
            pwm_out[i] = (r_periodAct[i] != '0) && (r_cnt[i] < r_dutyAct[i]);
        end
        irq = |(r_edgeStat & r_edgeEn);
    end

    assign gpio_out = r_gpioOut;

endmodule

// File: tb/tb_t03_mmio_periph.sv
// tb_t03_mmio_periph
// Directed bench for t03_mmio_periph. Each expected value is pushed onto a
// scoreboard queue as the stimulus is applied and popped when the matching
// DUT output is sampled, half a clock away from the rising edge.

module tb_t03_mmio_periph;

    localparam logic [31:0] BASE = 32'h31FFFF00;

    logic        clk;
    logic        rst;
    logic        write_mem;
    logic        read_mem;
    logic [31:0] data_address;
    logic [31:0] data_to_write;
    logic [31:0] data_from_mem;
    logic [31:0] data_read;
    logic        io_hit;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [1:0]  pwm_out;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expEntry_t;

    expEntry_t sbQueue[$];
    int        nChecks = 0;
    int        nFails  = 0;

    t03_mmio_periph #(
        .BASE_ADDR (BASE),
        .GPIO_W    (32),
        .NUM_PWM   (2),
        .PWM_W     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_mem     (write_mem),
        .read_mem      (read_mem),
        .data_address  (data_address),
        .data_to_write (data_to_write),
        .data_from_mem (data_from_mem),
        .data_read     (data_read),
        .io_hit        (io_hit),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .pwm_out       (pwm_out),
        .irq           (irq)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic pushExpected(input string tag, input logic [31:0] value);
        expEntry_t e;
        e.tag   = tag;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expEntry_t e;
        nChecks++;
        if (sbQueue.size() == 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_empty observed=%h", observed);
        end else begin
            e = sbQueue.pop_front();
            assert (observed === e.value) else begin
                nFails++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] expected, input logic [31:0] observed);
        pushExpected(tag, expected);
        checkOutput(observed);
    endtask

    task automatic applyStimulus(input logic wr, input logic rd,
                                 input logic [31:0] addr, input logic [31:0] data);
        write_mem     = wr;
        read_mem      = rd;
        data_address  = addr;
        data_to_write = data;
        #1;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic writeReg(input logic [31:0] offset, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, BASE + offset, data);
        idleCycle();
    endtask

    task automatic readReg(input logic [31:0] offset, input logic [31:0] expected, input string tag);
        applyStimulus(1'b0, 1'b1, BASE + offset, 32'h0);
        check(tag, expected, data_read);
    endtask

    initial begin
        rst           = 1'b1;
        write_mem     = 1'b0;
        read_mem      = 1'b0;
        data_address  = 32'h0;
        data_to_write = 32'h0;
        data_from_mem = 32'h0;
        gpio_in       = 32'h0;

        // Reset state
        #2;
        check("rst_gpio_out", 32'h0, gpio_out);
        check("rst_pwm_out",  32'h0, 32'(pwm_out));
        check("rst_irq",      32'h0, 32'(irq));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // GPIO_OUT store/load, unmapped pass-through and decode boundaries
        $display("[TB] GPIO_OUT and decode");
        writeReg(32'h00, 32'h000000A5);
        check("gpio_out_a5", 32'h000000A5, gpio_out);
        readReg(32'h00, 32'h000000A5, "read_gpio_out");
        check("io_hit_gpio_out", 32'h1, 32'(io_hit));
        data_from_mem = 32'hDEADBEEF;
        readReg(32'h40, 32'hDEADBEEF, "read_unmapped");
        check("io_hit_unmapped", 32'h0, 32'(io_hit));
        applyStimulus(1'b0, 1'b1, BASE + 32'h20, 32'h0);
        check("io_hit_past_last_pwm", 32'h0, 32'(io_hit));
        applyStimulus(1'b0, 1'b1, BASE + 32'h1C, 32'h0);
        check("io_hit_last_duty", 32'h1, 32'(io_hit));
        applyStimulus(1'b0, 1'b1, BASE + 32'h02, 32'h0);
        check("io_hit_misaligned", 32'h0, 32'(io_hit));
        idleCycle();

        // Input synchroniser and edge capture on bit 3
        $display("[TB] GPIO_IN edge capture");
        gpio_in = 32'h8;
        idleCycle();
        readReg(32'h04, 32'h0, "gpio_in_after_k");
        readReg(32'h08, 32'h0, "edge_stat_after_k");
        idleCycle();
        readReg(32'h04, 32'h8, "gpio_in_after_k1");
        readReg(32'h08, 32'h0, "edge_stat_after_k1");
        idleCycle();
        readReg(32'h08, 32'h8, "edge_stat_after_k2");
        check("irq_disabled", 32'h0, 32'(irq));
        writeReg(32'h0C, 32'h8);
        check("irq_enabled", 32'h1, 32'(irq));
        writeReg(32'h08, 32'h8);
        check("irq_cleared", 32'h0, 32'(irq));
        readReg(32'h08, 32'h0, "edge_stat_cleared");

        // Store and load in the same cycle: store wins, memory data returned
        data_from_mem = 32'h12345678;
        applyStimulus(1'b1, 1'b1, BASE, 32'h0000003C);
        check("both_strobes_data_read", 32'h12345678, data_read);
        check("both_strobes_io_hit", 32'h1, 32'(io_hit));
        idleCycle();
        check("both_strobes_gpio_out", 32'h0000003C, gpio_out);

        // W1C of bit 3 on the same edge that captures a new bit-3 edge
        $display("[TB] W1C versus new edge");
        gpio_in = 32'h0;
        repeat (3) idleCycle();
        gpio_in = 32'h8;
        idleCycle();
        idleCycle();
        applyStimulus(1'b1, 1'b0, BASE + 32'h08, 32'h8);
        idleCycle();
        readReg(32'h08, 32'h8, "edge_set_wins");
        check("irq_after_set_wins", 32'h1, 32'(irq));
        idleCycle();

        // PWM channel 0: period 9, duty 3; first cycle after setup runs with
        // the old duty of 0, later cycles are 3 high / 7 low
        $display("[TB] PWM channel 0");
        writeReg(32'h10, 32'h00000009);
        writeReg(32'h14, 32'hABCD0003);
        for (int j = 0; j < 30; j++) begin
            logic expHigh;
            expHigh = (j >= 10) && ((j % 10) < 3);
            check($sformatf("pwm0_p9d3_j%0d", j), {30'h0, 1'b0, expHigh}, 32'(pwm_out));
            idleCycle();
        end
        readReg(32'h10, 32'h9, "read_period0");
        readReg(32'h14, 32'h3, "read_duty0_truncated");
        idleCycle();
        writeReg(32'h14, 32'd10);
        repeat (12) idleCycle();
        for (int j = 0; j < 20; j++) begin
            check($sformatf("pwm0_duty_gt_period_j%0d", j), 32'h1, 32'(pwm_out));
            idleCycle();
        end
        writeReg(32'h10, 32'h0);
        repeat (12) idleCycle();
        for (int j = 0; j < 12; j++) begin
            check($sformatf("pwm0_period0_j%0d", j), 32'h0, 32'(pwm_out));
            idleCycle();
        end

        // PWM channel 1: duty changed 3 -> 6 mid-cycle takes effect next cycle
        $display("[TB] PWM channel 1 shadow update");
        writeReg(32'h18, 32'd9);
        writeReg(32'h1C, 32'd3);
        for (int j = 0; j < 40; j++) begin
            int  d;
            logic expHigh;
            d = (j < 10) ? 0 : ((j < 20) ? 3 : 6);
            expHigh = ((j % 10) < d);
            if (j == 11) applyStimulus(1'b1, 1'b0, BASE + 32'h1C, 32'd6);
            check($sformatf("pwm1_shadow_j%0d", j), {30'h0, expHigh, 1'b0}, 32'(pwm_out));
            idleCycle();
        end

        // Reset asserted between edges in the middle of a high phase
        $display("[TB] asynchronous reset mid-cycle");
        check("pre_rst_pwm", 32'h2, 32'(pwm_out));
        check("pre_rst_irq", 32'h1, 32'(irq));
        #1;
        rst     = 1'b1;
        gpio_in = 32'h0;
        #1;
        check("mid_rst_gpio_out", 32'h0, gpio_out);
        check("mid_rst_pwm_out",  32'h0, 32'(pwm_out));
        check("mid_rst_irq",      32'h0, 32'(irq));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        readReg(32'h00, 32'h0, "post_rst_gpio_out");
        readReg(32'h0C, 32'h0, "post_rst_edge_en");
        readReg(32'h08, 32'h0, "post_rst_edge_stat");
        idleCycle();
        readReg(32'h18, 32'h0, "post_rst_period1");
        readReg(32'h1C, 32'h0, "post_rst_duty1");
        check("post_rst_pwm_out", 32'h0, 32'(pwm_out));
        idleCycle();

        // Operation restarts from cnt = 0: period 4, duty 2 -> 2 high / 3 low
        writeReg(32'h10, 32'd4);
        writeReg(32'h14, 32'd2);
        for (int j = 0; j < 15; j++) begin
            logic expHigh;
            expHigh = (j >= 5) && ((j % 5) < 2);
            check($sformatf("pwm0_restart_j%0d", j), {30'h0, 1'b0, expHigh}, 32'(pwm_out));
            idleCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/t03_mmio_periph.md
T03_MMIO_PERIPH -- requirements
Module: t03_mmio_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h31FFFF00: byte address of register 0.
REQ-002 SHALL have parameter GPIO_W, default 32, range 1..32: GPIO pin count.
REQ-003 SHALL have parameter NUM_PWM, default 2, range 1..8: PWM channel count.
REQ-004 SHALL have parameter PWM_W, default 16, range 2..32: PWM counter width.
REQ-005 SHALL have port clk  in  1  sole clock; all flops on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port write_mem  in  1  CPU store strobe.
REQ-008 SHALL have port read_mem  in  1  CPU load strobe.
REQ-009 SHALL have port data_address  in  32  CPU byte address.
REQ-010 SHALL have port data_to_write  in  32  store data.
REQ-011 SHALL have port data_from_mem  in  32  memory read data, passed through on non-IO loads.
REQ-012 SHALL have port data_read  out  32  load data to CPU (combinational).
REQ-013 SHALL have port io_hit  out  1  high when data_address matches a mapped register (combinational).
REQ-014 SHALL have port gpio_in  in  GPIO_W  asynchronous input pins.
REQ-015 SHALL have port gpio_out  out  GPIO_W  output pin register.
REQ-016 SHALL have port pwm_out  out  NUM_PWM  PWM waveforms.
REQ-017 SHALL have port irq  out  1  level interrupt.

Function
REQ-018 SHALL decode exact addresses BASE_ADDR+offset: 0x00 GPIO_OUT (RW), 0x04 GPIO_IN (RO), 0x08 EDGE_STAT (R/W1C), 0x0C EDGE_EN (RW), 0x10+8*i PERIOD[i] (RW), 0x14+8*i DUTY[i] (RW), i < NUM_PWM; anything else unmapped.
REQ-019 SHALL, for write_mem with a mapped address, update the register at the next clock edge; writes to GPIO_IN and unmapped addresses have no effect.
REQ-020 SHALL, for read_mem with a mapped address, drive data_read with the register value zero-extended to 32 bits; PERIOD/DUTY reads return the shadow value.
REQ-021 SHALL drive data_read = data_from_mem when no read_mem, unmapped address, or write_mem is high (write priority when both strobes high).
REQ-022 SHALL store only the low GPIO_W / PWM_W bits of writes; upper bits ignored.
REQ-023 SHALL synchronise gpio_in through two flops (s1, s2) and a third history flop s3; GPIO_IN reads s2.
REQ-024 SHALL set EDGE_STAT[b] on the clock edge where s2[b] & ~s3[b]; set wins over a same-cycle W1C clear of that bit.
REQ-025 SHALL clear EDGE_STAT bits written with 1; bits written with 0 unchanged.
REQ-026 SHALL drive irq = |(EDGE_STAT & EDGE_EN), combinational.
REQ-027 SHALL keep per channel an active period/duty pair loaded from shadow PERIOD/DUTY, and a PWM_W-bit counter cnt.
REQ-028 SHALL, per clock: if active period == 0, hold cnt = 0 and load shadows; else if cnt == active period, cnt <= 0 and load shadows; else cnt <= cnt+1.
REQ-029 SHALL drive pwm_out[i] = (active period != 0) && (cnt < active duty), combinational; PWM cycle is period+1 clocks, high time min(duty, period+1) clocks.
REQ-030 SHALL, when a shadow write and a shadow load coincide, load the old shadow value; the new value takes effect at the following wrap (glitch-free, no truncated cycle).
REQ-031 SHALL give duty == 0 constant low and duty > period constant high while period != 0.

Reset
REQ-032 SHALL on rst clear all registers, shadows, active values, counters and sync flops to 0 immediately, giving gpio_out = 0, pwm_out = 0, irq = 0; rst mid-PWM-cycle aborts the cycle, and operation restarts at cnt = 0 after release.

Verification
REQ-033 SHALL test: store 0xA5 to BASE+0x00, then load BASE+0x00 -> gpio_out = 0xA5, data_read = 0x000000A5; load unmapped BASE+0x40 -> data_read = data_from_mem, io_hit = 0.
REQ-034 SHALL test: gpio_in[3] 0->1 sampled at edge k -> GPIO_IN bit 3 readable after edge k+1, EDGE_STAT bit 3 set after edge k+2; EDGE_EN = 0x8 -> irq = 1; W1C 0x8 -> irq = 0 next cycle.
REQ-035 SHALL test: PERIOD[0] = 9, DUTY[0] = 3 -> pwm_out[0] repeats 3 clocks high, 7 low; DUTY[0] = 10 -> constant high; PERIOD[0] = 0 -> constant low.
REQ-036 SHALL test: DUTY[1] changed 3->6 mid-cycle with PERIOD[1] = 9 -> current cycle keeps 3 high clocks, next cycle 6.
REQ-037 SHALL test: W1C of bit 3 in the same cycle as a new bit-3 edge -> bit stays 1; write_mem and read_mem both high at BASE+0x00 -> register written, data_read = data_from_mem.
REQ-038 SHALL test: rst asserted mid-PWM-cycle and between clock edges -> all outputs 0 before the next clock edge, registers read 0 after release.
